// File: rtl/plab5_mcore_mem_req_cmsg_arb_pack_pkg.sv
`default_nettype none
// ============================================================================
// plab5_mcore_mem_req_cmsg_arb_pack_pkg: memory request control-message widths and type codes
// Rev 1.0
// ============================================================================
package plab5_mcore_mem_req_cmsg_arb_pack_pkg;

  localparam int TYPE_NBITS  = 3;
  localparam int QUEUE_DEPTH = 2;

  typedef enum logic [TYPE_NBITS-1:0] {
    MEM_TYPE_READ       = 3'd0,
    MEM_TYPE_WRITE      = 3'd1,
    MEM_TYPE_WRITE_INIT = 3'd2,
    MEM_TYPE_AMO_ADD    = 3'd3
  } mem_type_e;

  // Port index width never drops to zero, even for a single requester.
  function automatic int idx_nbits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int len_nbits(input int data_nbits);
    return $clog2(data_nbits / 8);
  endfunction

  function automatic int cmsg_nbits(input int o, input int a, input int d);
    return TYPE_NBITS + o + a + len_nbits(d);
  endfunction

endpackage
`default_nettype wire

// File: rtl/plab5_mcore_rr_arb.sv
`default_nettype none
// ============================================================================
// plab5_mcore_rr_arb: N-way round-robin arbiter, pointer advances past the winner when en=1
// Rev 1.0
// ============================================================================
module plab5_mcore_rr_arb
  import plab5_mcore_mem_req_cmsg_arb_pack_pkg::*;
#(
  parameter int p_num_reqs = 4,
  localparam int K = idx_nbits(p_num_reqs)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [p_num_reqs-1:0] reqs,
  output logic [p_num_reqs-1:0] grants,
  output logic [K-1:0]          grant_idx,
  output logic                  grant_any
);

  localparam logic [K-1:0] LAST = K'(p_num_reqs - 1);

  logic [K-1:0] ptr;
  int           cand;

  // Scan starting at the priority pointer; the first valid request wins.
  always_comb begin
    grants    = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int off = 0; off < p_num_reqs; off++) begin
      cand = (int'(ptr) + off) % p_num_reqs;
      if (!grant_any && reqs[cand]) begin
        grant_any    = 1'b1;
        grants[cand] = 1'b1;
        grant_idx    = cand[K-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/plab5_mcore_mem_req_cmsg_arb_pack.sv
`default_nettype none
// ============================================================================
// plab5_mcore_mem_req_cmsg_arb_pack: round-robin multi-port memory request packer with 2-entry output queue
// Rev 1.0
// ============================================================================
module plab5_mcore_mem_req_cmsg_arb_pack
  import plab5_mcore_mem_req_cmsg_arb_pack_pkg::*;
#(
  parameter int p_num_ports    = 4,
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 32,
  parameter int p_tag_opaque   = 1,
  localparam int N = p_num_ports,
  localparam int O = p_opaque_nbits,
  localparam int A = p_addr_nbits,
  localparam int L = len_nbits(p_data_nbits),
  localparam int C = cmsg_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits),
  localparam int K = idx_nbits(p_num_ports)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N-1:0]            in_val,
  output logic [N-1:0]            in_rdy,
  input  logic [N-1:0]            in_domain,
  input  logic [N*TYPE_NBITS-1:0] in_type,
  input  logic [N*O-1:0]          in_opaque,
  input  logic [N*A-1:0]          in_addr,
  input  logic [N*L-1:0]          in_len,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic                    out_domain,
  output logic [C-1:0]            out_msg,
  output logic [K-1:0]            out_port
);

  localparam bit           TAG_ON    = (p_tag_opaque != 0) && (N > 1);
  localparam logic [O-1:0] KEEP_MASK = TAG_ON ? ({O{1'b1}} >> K) : {O{1'b1}};

  logic [N-1:0]            grants;
  logic [K-1:0]            grant_idx;
  logic                    grant_any;
  logic                    space, enq, deq;
  logic [TYPE_NBITS-1:0]   sel_type;
  logic [O-1:0]            sel_opaque, enq_opaque;
  logic [A-1:0]            sel_addr;
  logic [L-1:0]            sel_len;
  logic [C-1:0]            enq_msg;

  logic [1:0]              count;
  logic                    head, tail;
  logic [C-1:0]            q_msg  [QUEUE_DEPTH];
  logic [K-1:0]            q_port [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0]  q_dom;
  logic [C-1:0]            last_msg;
  logic [K-1:0]            last_port;
  logic                    last_dom;

  assign space  = (count < 2'd2) && !reset;
  assign in_rdy = space ? grants : '0;
  assign enq    = space && grant_any;
  assign deq    = out_val && out_rdy;

  plab5_mcore_rr_arb #(.p_num_reqs(N)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .en        (enq),
    .reqs      (in_val),
    .grants    (grants),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign sel_type   = in_type[TYPE_NBITS*int'(grant_idx) +: TYPE_NBITS];
  assign sel_opaque = in_opaque[O*int'(grant_idx) +: O];
  assign sel_addr   = in_addr[A*int'(grant_idx) +: A];
  assign sel_len    = in_len[L*int'(grant_idx) +: L];

  // Tagging replaces the top K opaque bits with the winning port index.
  assign enq_opaque = (sel_opaque & KEEP_MASK) | (TAG_ON ? (O'(grant_idx) << (O - K)) : '0);
  assign enq_msg    = {sel_type, enq_opaque, sel_addr, sel_len};

  // With count<2 the free slot is the head when empty, the other slot otherwise.
  assign tail = head ^ count[0];

  always_ff @(posedge clk) begin
    if (enq) begin
      q_msg[tail]  <= enq_msg;
      q_port[tail] <= grant_idx;
      q_dom[tail]  <= in_domain[grant_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      head      <= 1'b0;
      last_msg  <= '0;
      last_port <= '0;
      last_dom  <= 1'b0;
    end else begin
      if (deq) begin
        head      <= ~head;
        last_msg  <= q_msg[head];
        last_port <= q_port[head];
        last_dom  <= q_dom[head];
      end
      count <= count + {1'b0, enq} - {1'b0, deq};
    end
  end

  // When empty the outputs show the most recently dequeued entry.
  assign out_val    = (count != 2'd0) && !reset;
  assign out_msg    = (count != 2'd0) ? q_msg[head]  : last_msg;
  assign out_port   = (count != 2'd0) ? q_port[head] : last_port;
  assign out_domain = (count != 2'd0) ? q_dom[head]  : last_dom;

endmodule
`default_nettype wire
